// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one SPI mode-0 master (MSB first) between two
// byte-level requesters with round-robin arbitration and locked multi-byte
// frames (SS held low and grant held until the owner marks the last byte).
module spi_xfer_arbiter #(
  parameter int DIV      = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk_26,
  input  logic       RESET_N,
  input  logic       r0_req,
  input  logic [7:0] r0_tx,
  input  logic       r0_last,
  output logic       r0_ack,
  output logic [7:0] r0_rx,
  input  logic       r1_req,
  input  logic [7:0] r1_tx,
  input  logic       r1_last,
  output logic       r1_ack,
  output logic [7:0] r1_rx,
  output logic       busy,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam logic [15:0] GAP_M1 = 16'(IDLE_GAP - 1);

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  tx_sh_r;
  logic [7:0]  rx_sh_r;
  logic        last_r;
  logic        owner_r;
  logic        last_owner_r;
  logic        ss_r;
  logic        sclk_r;
  logic        mosi_r;
  logic        busy_r;
  logic        r0_ack_r;
  logic        r1_ack_r;
  logic [7:0]  r0_rx_r;
  logic [7:0]  r1_rx_r;

  logic        grant_v_s;
  logic        grant_id_s;
  logic        pick_id_s;
  logic [7:0]  pick_tx_s;
  logic        pick_last_s;
  logic        own_req_s;

  // Round-robin choice in IDLE, and operand mux for whichever requester is being loaded.
  always_comb begin
    grant_v_s   = r0_req | r1_req;
    grant_id_s  = 1'b0;
    pick_id_s   = 1'b0;
    pick_tx_s   = 8'h00;
    pick_last_s = 1'b0;
    own_req_s   = 1'b0;
    if (r0_req && r1_req) begin
      grant_id_s = ~last_owner_r;
    end else if (r1_req) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
    if (state_r == HOLD) begin
      pick_id_s = owner_r;
    end else begin
      pick_id_s = grant_id_s;
    end
    if (pick_id_s) begin
      pick_tx_s   = r1_tx;
      pick_last_s = r1_last;
    end else begin
      pick_tx_s   = r0_tx;
      pick_last_s = r0_last;
    end
    if (owner_r) begin
      own_req_s = r1_req;
    end else begin
      own_req_s = r0_req;
    end
  end

  // Arbitration / SPI shift state machine with registered pins and handshakes.
  always_ff @(posedge clk_26) begin
    if (!RESET_N) begin
      state_r      <= IDLE;
      cnt_r        <= 16'd0;
      bit_cnt_r    <= 3'd0;
      tx_sh_r      <= 8'h00;
      rx_sh_r      <= 8'h00;
      last_r       <= 1'b0;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      ss_r         <= 1'b1;
      sclk_r       <= 1'b0;
      mosi_r       <= 1'b0;
      busy_r       <= 1'b0;
      r0_ack_r     <= 1'b0;
      r1_ack_r     <= 1'b0;
      r0_rx_r      <= 8'h00;
      r1_rx_r      <= 8'h00;
    end else begin
      r0_ack_r <= 1'b0;
      r1_ack_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_v_s) begin
            tx_sh_r <= pick_tx_s;
            last_r  <= pick_last_s;
            owner_r <= pick_id_s;
            ss_r    <= 1'b0;
            mosi_r  <= pick_tx_s[7];
            cnt_r   <= 16'd0;
            busy_r  <= 1'b1;
            state_r <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_r == DIV_M1) begin
            cnt_r     <= 16'd0;
            bit_cnt_r <= 3'd0;
            state_r   <= SHIFT;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        SHIFT: begin
          if (cnt_r == DIV_M1) begin
            cnt_r <= 16'd0;
            if (!sclk_r) begin
              // rising edge: capture MISO into the LSB
              sclk_r  <= 1'b1;
              rx_sh_r <= {rx_sh_r[6:0], MISO};
            end else begin
              // falling edge: either finish the byte or present the next bit
              sclk_r <= 1'b0;
              if (bit_cnt_r == 3'd7) begin
                state_r <= DONE;
                if (owner_r) begin
                  r1_ack_r <= 1'b1;
                  r1_rx_r  <= rx_sh_r;
                end else begin
                  r0_ack_r <= 1'b1;
                  r0_rx_r  <= rx_sh_r;
                end
              end else begin
                mosi_r    <= tx_sh_r[6];
                tx_sh_r   <= {tx_sh_r[6:0], 1'b0};
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        DONE: begin
          last_owner_r <= owner_r;
          if (last_r) begin
            ss_r    <= 1'b1;
            mosi_r  <= 1'b0;
            cnt_r   <= 16'd0;
            state_r <= GAP;
          end else begin
            state_r <= HOLD;
          end
        end
        HOLD: begin
          // frame is locked: only the owner may continue, straight into SHIFT
          if (own_req_s) begin
            tx_sh_r   <= pick_tx_s;
            last_r    <= pick_last_s;
            mosi_r    <= pick_tx_s[7];
            cnt_r     <= 16'd0;
            bit_cnt_r <= 3'd0;
            state_r   <= SHIFT;
          end
        end
        GAP: begin
          if (cnt_r == GAP_M1) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          ss_r    <= 1'b1;
          sclk_r  <= 1'b0;
          mosi_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign r0_ack = r0_ack_r;
  assign r1_ack = r1_ack_r;
  assign r0_rx  = r0_rx_r;
  assign r1_rx  = r1_rx_r;
  assign busy   = busy_r;
  assign SS     = ss_r;
  assign SCLK   = sclk_r;
  assign MOSI   = mosi_r;

endmodule
